// File: rtl/bit_population_counter_pkg.sv
// Shared sizing helpers for the pipelined population counter.
//   n_leaves    : number of LEAF-wide chunks covering a word (padded up)
//   tree_levels : registered adder-tree depth over those leaves
//   cnt_width   : bits needed to hold a count of 0..width
//   lvl_cnt     : operand count entering tree level lvl
//   leaf_pop    : combinational popcount of one (zero-extended) leaf
package bit_population_counter_pkg;

  function automatic int n_leaves(input int width, input int leaf);
    return (width + leaf - 1) / leaf;
  endfunction

  function automatic int tree_levels(input int width, input int leaf);
    return $clog2(n_leaves(width, leaf));
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // ceil(leaves / 2^lvl): each level halves the operand count, odd one rides along
  function automatic int lvl_cnt(input int leaves, input int lvl);
    return (leaves + (1 << lvl) - 1) >> lvl;
  endfunction

  localparam int LEAVES = n_leaves(16, 4);

  function automatic logic [3:0] leaf_pop(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/popcount_adder_stage.sv
// One registered level of the popcount adder tree.
//   clk, rst_n    : clock, async active-low reset
//   en            : global pipeline enable (stall = hold)
//   vld, last     : side-band of the beat entering this level
//   sum           : IN_CNT operands, IN_W bits each
//   vld_q, last_q : registered side-band
//   sum_q         : ceil(IN_CNT/2) sums, IN_W+1 bits each
module popcount_adder_stage #(
  parameter int IN_CNT = 2,
  parameter int IN_W   = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                vld,
  input  logic                                last,
  input  logic [IN_CNT-1:0][IN_W-1:0]         sum,
  output logic                                vld_q,
  output logic                                last_q,
  output logic [(IN_CNT+1)/2-1:0][IN_W:0]     sum_q
);

  logic [(IN_CNT+1)/2-1:0][IN_W:0] sum_d;

  for (genvar j = 0; j < (IN_CNT + 1) / 2; j++) begin : g_pair
    if (2 * j + 1 < IN_CNT) begin : g_add
      assign sum_d[j] = {1'b0, sum[2*j]} + {1'b0, sum[2*j+1]};
    end else begin : g_pass
      // odd trailing operand: widen and pass through
      assign sum_d[j] = {1'b0, sum[2*j]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      sum_q  <= '0;
    end else if (en) begin
      vld_q  <= vld;
      last_q <= last;
      sum_q  <= sum_d;
    end
  end

endmodule

// File: rtl/bit_population_counter_pipe.sv
// Pipelined, back-pressured population counter with per-packet accumulation.
// Leaf stage -> N registered adder levels -> saturating accumulator/output.
//   clk_i, rst_n_i : clock, async active-low reset
//   data_i         : WIDTH-bit word; zeros_i selects counting zeros
//   last_i         : beat closes the packet
//   valid_i/ready_o: input stream handshake
//   data_o, ovf_o  : packet count and sticky saturation flag
//   valid_o/ready_i: output stream handshake
module bit_population_counter_pipe
  import bit_population_counter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LEAF_WIDTH = 4,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 zeros_i,
  input  logic                 last_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [ACC_WIDTH-1:0] data_o,
  output logic                 ovf_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int NL = n_leaves(WIDTH, LEAF_WIDTH);
  localparam int N  = tree_levels(WIDTH, LEAF_WIDTH);
  localparam int PW = NL * LEAF_WIDTH;
  localparam int LW = cnt_width(LEAF_WIDTH);
  localparam int TW = LW + N;
  localparam int SW = ((ACC_WIDTH > TW) ? ACC_WIDTH : TW) + 1;

  // Single global enable: the whole pipe advances or holds together, so
  // bubbles keep their slots during a stall.
  logic en;
  assign en      = !valid_o || ready_i;
  assign ready_o = en;

  // ---------------- leaf stage ----------------
  logic [PW-1:0] pad, mask, sel;
  assign pad  = PW'(data_i);
  assign mask = PW'({WIDTH{1'b1}});
  // padding bits are zero in pad, and masked off when inverting
  assign sel  = zeros_i ? (~pad & mask) : pad;

  logic [NL-1:0][LW-1:0] leaf_d, leaf_q;
  logic                  leaf_vld, leaf_last;

  for (genvar j = 0; j < NL; j++) begin : g_leaf
    logic [7:0] chunk;
    assign chunk     = 8'(sel[j*LEAF_WIDTH +: LEAF_WIDTH]);
    assign leaf_d[j] = LW'(leaf_pop(chunk));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      leaf_vld  <= 1'b0;
      leaf_last <= 1'b0;
      leaf_q    <= '0;
    end else if (en) begin
      leaf_vld  <= valid_i;
      leaf_last <= last_i;
      leaf_q    <= leaf_d;
    end
  end

  // ---------------- adder tree ----------------
  for (genvar k = 0; k < N; k++) begin : g_lvl
    localparam int CI = lvl_cnt(NL, k);
    localparam int WI = LW + k;
    logic [CI-1:0][WI-1:0]       sum_in;
    logic [(CI+1)/2-1:0][WI:0]   sum_q;
    logic                        vld_in, last_in, vld_q, last_q;

    if (k == 0) begin : g_src
      assign sum_in  = leaf_q;
      assign vld_in  = leaf_vld;
      assign last_in = leaf_last;
    end else begin : g_src
      assign sum_in  = g_lvl[k-1].sum_q;
      assign vld_in  = g_lvl[k-1].vld_q;
      assign last_in = g_lvl[k-1].last_q;
    end

    popcount_adder_stage #(.IN_CNT(CI), .IN_W(WI)) u_stage (
      .clk    (clk_i),
      .rst_n  (rst_n_i),
      .en     (en),
      .vld    (vld_in),
      .last   (last_in),
      .sum    (sum_in),
      .vld_q  (vld_q),
      .last_q (last_q),
      .sum_q  (sum_q)
    );
  end

  logic [TW-1:0] wc;
  logic          wc_vld, wc_last;

  if (N == 0) begin : g_out
    assign wc      = leaf_q[0];
    assign wc_vld  = leaf_vld;
    assign wc_last = leaf_last;
  end else begin : g_out
    assign wc      = g_lvl[N-1].sum_q[0];
    assign wc_vld  = g_lvl[N-1].vld_q;
    assign wc_last = g_lvl[N-1].last_q;
  end

  // ---------------- accumulate / output ----------------
  logic [ACC_WIDTH-1:0] acc, acc_next;
  logic                 flag, flag_next, sat;
  logic [SW-1:0]        sum_full;

  assign sum_full  = SW'(acc) + SW'(wc);
  assign sat       = sum_full > SW'({ACC_WIDTH{1'b1}});
  assign acc_next  = sat ? {ACC_WIDTH{1'b1}} : sum_full[ACC_WIDTH-1:0];
  assign flag_next = flag | sat;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc     <= '0;
      flag    <= 1'b0;
      data_o  <= '0;
      ovf_o   <= 1'b0;
      valid_o <= 1'b0;
    end else if (en) begin
      // en=1 means any held result was consumed (or none was pending)
      valid_o <= wc_vld && wc_last;
      if (wc_vld) begin
        if (wc_last) begin
          data_o <= acc_next;
          ovf_o  <= flag_next;
          acc    <= '0;
          flag   <= 1'b0;
        end else begin
          acc    <= acc_next;
          flag   <= flag_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_population_counter_pipe.sv
// Self-checking bench: default instance driven through a scoreboard
// (table vectors, latency, stall and reset sequences), plus an ACC_WIDTH=5
// instance for saturation and a WIDTH=13 instance for padding.
module tb_bit_population_counter_pipe;

  typedef struct {
    logic [15:0] data;
    logic        zeros;
    logic        last;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] cnt;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // default instance
  logic [15:0] d_data = '0;
  logic        d_zeros = 1'b0, d_last = 1'b0, d_valid = 1'b0, d_rdy_i = 1'b1;
  logic        d_ready_o, d_ovf, d_vout;
  logic [15:0] d_out;

  bit_population_counter_pipe u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(d_data), .zeros_i(d_zeros),
    .last_i(d_last), .valid_i(d_valid), .ready_o(d_ready_o), .data_o(d_out),
    .ovf_o(d_ovf), .valid_o(d_vout), .ready_i(d_rdy_i));

  // ACC_WIDTH=5 instance
  logic [15:0] a_data = '0;
  logic        a_zeros = 1'b0, a_last = 1'b0, a_valid = 1'b0, a_rdy_i = 1'b1;
  logic        a_ready_o, a_ovf, a_vout;
  logic [4:0]  a_out;

  bit_population_counter_pipe #(.ACC_WIDTH(5)) u_acc5 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(a_data), .zeros_i(a_zeros),
    .last_i(a_last), .valid_i(a_valid), .ready_o(a_ready_o), .data_o(a_out),
    .ovf_o(a_ovf), .valid_o(a_vout), .ready_i(a_rdy_i));

  // WIDTH=13 instance
  logic [12:0] p_data = '0;
  logic        p_zeros = 1'b0, p_last = 1'b0, p_valid = 1'b0, p_rdy_i = 1'b1;
  logic        p_ready_o, p_ovf, p_vout;
  logic [15:0] p_out;

  bit_population_counter_pipe #(.WIDTH(13), .LEAF_WIDTH(4)) u_w13 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(p_data), .zeros_i(p_zeros),
    .last_i(p_last), .valid_i(p_valid), .ready_o(p_ready_o), .data_o(p_out),
    .ovf_o(p_ovf), .valid_o(p_vout), .ready_i(p_rdy_i));

  res_t sb[$];
  res_t r1[$];
  res_t r2[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // scoreboard monitor for the default instance
  always @(negedge clk) begin
    if (rst_n && d_vout && d_rdy_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(d_out), 32'hFFFF_FFFF);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("sb_data", 32'(d_out), 32'(e.cnt));
        chk("sb_ovf", 32'(d_ovf), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && a_vout) r1.push_back('{cnt: 16'(a_out), ovf: a_ovf});
    if (rst_n && p_vout) r2.push_back('{cnt: p_out, ovf: p_ovf});
  end

  // Called at posedge+#1; returns at posedge+#1 after the beat is accepted.
  task automatic send0(input logic [15:0] d, input logic z, input logic l);
    bit acc;
    int n;
    d_data = d; d_zeros = z; d_last = l; d_valid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = d_ready_o;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout: beat %h not accepted", d);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); n++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk(nm, sb.size(), 0);
  endtask

  vec_t vt[11];
  logic [15:0] sw[8];
  logic [15:0] hold_d;

  initial begin
    vt[0]  = '{16'hE70F, 1'b0, 1'b1, 16'd10};
    vt[1]  = '{16'hE70F, 1'b1, 1'b1, 16'd6};
    vt[2]  = '{16'hFFFF, 1'b0, 1'b0, 16'd0};
    vt[3]  = '{16'h0001, 1'b0, 1'b0, 16'd0};
    vt[4]  = '{16'h8000, 1'b0, 1'b1, 16'd18};
    vt[5]  = '{16'h0000, 1'b0, 1'b1, 16'd0};
    vt[6]  = '{16'h0000, 1'b1, 1'b1, 16'd16};
    vt[7]  = '{16'h0F0F, 1'b1, 1'b0, 16'd0};
    vt[8]  = '{16'h00FF, 1'b0, 1'b1, 16'd16};
    vt[9]  = '{16'hA5A5, 1'b0, 1'b1, 16'd8};
    vt[10] = '{16'hFFFF, 1'b0, 1'b1, 16'd16};
    sw = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F, 16'h003F, 16'h007F, 16'h00FF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", d_vout, 0);
    chk("rst_data", d_out, 0);
    chk("rst_ovf", d_ovf, 0);
    chk("rst_ready", d_ready_o, 1);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // latency: valid_o appears after exactly 4 edges, for one cycle
    sb.push_back('{cnt: 16'd10, ovf: 1'b0});
    send0(16'hE70F, 1'b0, 1'b1);
    d_valid = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      if (e > 1) begin @(posedge clk); #1; end
      chk($sformatf("latency_edge%0d", e), d_vout, (e == 4) ? 1 : 0);
    end
    drain("lat_drain");

    // table vectors, back-to-back
    for (int i = 0; i < 11; i++) begin
      if (vt[i].last) sb.push_back('{cnt: vt[i].exp, ovf: 1'b0});
      send0(vt[i].data, vt[i].zeros, vt[i].last);
    end
    d_valid = 1'b0;
    drain("table_drain");

    // 8-word stream with a 3-cycle consumer stall
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          sb.push_back('{cnt: 16'($countones(sw[i])), ovf: 1'b0});
          send0(sw[i], 1'b0, 1'b1);
        end
        d_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 d_rdy_i = 1'b0;
        @(negedge clk);
        chk("stall_valid", d_vout, 1);
        chk("stall_ready0", d_ready_o, 0);
        hold_d = d_out;
        for (int s = 1; s < 3; s++) begin
          @(negedge clk);
          chk("stall_ready", d_ready_o, 0);
          chk("stall_hold_valid", d_vout, 1);
          chk("stall_hold_data", d_out, hold_d);
        end
        @(posedge clk); #1 d_rdy_i = 1'b1;
      end
    join
    drain("stall_drain");

    // reset mid-packet discards the partial sum
    send0(16'hFFFF, 1'b0, 1'b0);
    send0(16'hFFFF, 1'b0, 1'b0);
    d_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", d_vout, 0);
    chk("midrst_data", d_out, 0);
    chk("midrst_ready", d_ready_o, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{cnt: 16'd4, ovf: 1'b0});
    send0(16'h000F, 1'b0, 1'b1);
    d_valid = 1'b0;
    drain("midrst_drain");

    // saturation (ACC_WIDTH=5) and padding (WIDTH=13), driven together
    a_data = 16'hFFFF; a_last = 1'b0; a_valid = 1'b1;
    p_data = 13'h0000; p_zeros = 1'b1; p_last = 1'b1; p_valid = 1'b1;
    @(posedge clk); #1;
    a_last = 1'b1;
    p_data = 13'h1FFF; p_zeros = 1'b0;
    @(posedge clk); #1;
    a_data = 16'h0003;
    p_data = 13'h1555; p_zeros = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; p_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("acc5_count", r1.size(), 2);
    if (r1.size() == 2) begin
      chk("acc5_sat_data", 32'(r1[0].cnt), 31);
      chk("acc5_sat_ovf", 32'(r1[0].ovf), 1);
      chk("acc5_next_data", 32'(r1[1].cnt), 2);
      chk("acc5_next_ovf", 32'(r1[1].ovf), 0);
    end
    chk("w13_count", r2.size(), 3);
    if (r2.size() == 3) begin
      chk("w13_zeros_pad", 32'(r2[0].cnt), 13);
      chk("w13_ones_full", 32'(r2[1].cnt), 13);
      chk("w13_zeros_mix", 32'(r2[2].cnt), 6);
      chk("w13_ovf", 32'(r2[0].ovf), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
